// File: rtl/param_ppc_pkg.sv
// Shared constants for the ping-pong / wrap counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package param_ppc_pkg;

  // mode input encoding
  localparam logic MODE_PINGPONG = 1'b0;
  localparam logic MODE_WRAP     = 1'b1;

  // direction output encoding
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : param_ppc_pkg

// File: rtl/param_ping_pong_counter.sv
// Bounded up/down counter that bounces (ping-pong) or rolls over (wrap) at [min,max].
// Latency: inputs sampled at a rising edge appear on out/direction/turn right after that edge.
// Backpressure: none; enable=0 or an invalid range (max <= min) freezes all state.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset (out=0, direction=up, turn=0)
//   enable    - count enable; low holds state and ignores flip
//   mode      - MODE_PINGPONG bounces at the bounds, MODE_WRAP rolls over
//   flip      - reverse direction for this step (only when enabled)
//   min, max  - inclusive bounds, used live every cycle (no internal copy)
//   direction - registered current direction (DIR_UP / DIR_DOWN)
//   out       - registered counter value
//   turn      - registered one-cycle pulse on a bounce or wrap
module param_ping_pong_counter
  import param_ppc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             flip,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  output logic             direction,
  output logic [WIDTH-1:0] out,
  output logic             turn
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;

  logic range_ok;
  logic in_range;
  logic eff_dir;

  // Unsigned compares; a valid range guarantees max-1 >= min and min+1 <= max,
  // so every update below stays inside [min,max] even at 0 or 2^WIDTH-1.
  assign range_ok = (max > min);
  assign in_range = (out_q >= min) && (out_q <= max);
  assign eff_dir  = dir_q ^ flip;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    turn_d = 1'b0;

    if (enable && range_ok) begin
      if (!in_range) begin
        // Counter fell outside the live bounds (reset, or bounds moved):
        // snap to the bottom and count up.
        out_d = min;
        dir_d = DIR_UP;
      end else if (eff_dir == DIR_UP) begin
        if (out_q < max) begin
          out_d = out_q + ONE;
          dir_d = DIR_UP;
        end else if (mode == MODE_WRAP) begin
          out_d  = min;
          dir_d  = DIR_UP;
          turn_d = 1'b1;
        end else begin
          out_d  = max - ONE;
          dir_d  = DIR_DOWN;
          turn_d = 1'b1;
        end
      end else begin
        if (out_q > min) begin
          out_d = out_q - ONE;
          dir_d = DIR_DOWN;
        end else if (mode == MODE_WRAP) begin
          out_d  = max;
          dir_d  = DIR_DOWN;
          turn_d = 1'b1;
        end else begin
          out_d  = min + ONE;
          dir_d  = DIR_UP;
          turn_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= DIR_UP;
      turn_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      turn_q <= turn_d;
    end
  end

  assign out       = out_q;
  assign direction = dir_q;
  assign turn      = turn_q;

endmodule : param_ping_pong_counter

// File: tb/tb_param_ping_pong_counter.sv
// Self-checking bench for param_ping_pong_counter (WIDTH=4).
// Latency: compares outputs 1 time unit after each rising edge and at falling edges.
// Backpressure: n/a.
module tb_param_ping_pong_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       mode;
  logic       flip;
  logic [3:0] min_b;
  logic [3:0] max_b;
  logic       dir_w;
  logic [3:0] out_w;
  logic       turn_w;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state, held as plain integers
  int m_out;
  int m_dir;
  int m_turn;

  param_ping_pong_counter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .flip      (flip),
    .min       (min_b),
    .max       (max_b),
    .direction (dir_w),
    .out       (out_w),
    .turn      (turn_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: take one step of size +/-1 and, if it leaves the range,
  // either reflect it (ping-pong) or jump to the opposite bound (wrap).
  always @(posedge clk) begin
    int lo, hi, d, step, tgt;
    lo = int'(min_b);
    hi = int'(max_b);
    if (rst) begin
      m_out = 0; m_dir = 1; m_turn = 0;
    end else if (!enable || hi <= lo) begin
      m_turn = 0;
    end else if (m_out < lo || m_out > hi) begin
      m_out = lo; m_dir = 1; m_turn = 0;
    end else begin
      d    = (m_dir != 0) != (flip != 0) ? 1 : 0;
      step = d ? 1 : -1;
      tgt  = m_out + step;
      if (tgt >= lo && tgt <= hi) begin
        m_out = tgt; m_dir = d; m_turn = 0;
      end else if (mode == 1'b0) begin
        m_out = m_out - step; m_dir = 1 - d; m_turn = 1;
      end else begin
        m_out = d ? lo : hi; m_dir = d; m_turn = 1;
      end
    end
    #1;
    if (chk_en) begin
      chk("model_out",  32'(out_w),  32'(m_out));
      chk("model_dir",  32'(dir_w),  32'(m_dir));
      chk("model_turn", 32'(turn_w), 32'(m_turn));
    end
  end

  // Advance one cycle; inputs change and literals are checked at the falling edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int e_out, input int e_dir, input int e_turn);
    chk({nm, "_out"},  32'(out_w),  32'(e_out));
    chk({nm, "_dir"},  32'(dir_w),  32'(e_dir));
    chk({nm, "_turn"}, 32'(turn_w), 32'(e_turn));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 1'b0; flip = 1'b0;
    min_b = 4'd0; max_b = 4'd15;
    chk_en = 1'b1;

    // Full-range ping-pong
    cyc();           lit("reset", 0, 1, 0);
    rst = 1'b0;
    cyc(15);         lit("pp_top", 15, 1, 0);
    cyc();           lit("pp_bounce_hi", 14, 0, 1);
    cyc();           lit("pp_after_hi", 13, 0, 0);
    cyc(13);         lit("pp_bottom", 0, 0, 0);
    cyc();           lit("pp_bounce_lo", 1, 1, 1);
    cyc();           lit("pp_after_lo", 2, 1, 0);

    // Wrap in [3,6] from reset
    mode = 1'b1; min_b = 4'd3; max_b = 4'd6; rst = 1'b1;
    cyc();           lit("wr_reset", 0, 1, 0);
    rst = 1'b0;
    cyc();           lit("wr_resync", 3, 1, 0);
    cyc(3);          lit("wr_max", 6, 1, 0);
    cyc();           lit("wr_wrap", 3, 1, 1);
    cyc();           lit("wr_after", 4, 1, 0);

    // Flip behaviour in full-range ping-pong
    mode = 1'b0; min_b = 4'd0; max_b = 4'd15; rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(5);          lit("fl_at5", 5, 1, 0);
    flip = 1'b1;
    cyc();           lit("fl_rev", 4, 0, 0);
    flip = 1'b0;
    cyc(4);          lit("fl_down0", 0, 0, 0);
    cyc();           lit("fl_bounce", 1, 1, 1);
    cyc(14);         lit("fl_at15", 15, 1, 0);
    flip = 1'b1;
    cyc();           lit("fl_top_noturn", 14, 0, 0);
    flip = 1'b0;

    // Wrap downward, including the 0 / 15 extremes
    mode = 1'b1; min_b = 4'd3; max_b = 4'd6;
    cyc();           lit("wd_resync", 3, 1, 0);
    flip = 1'b1;
    cyc();           lit("wd_wrap_lo", 6, 0, 1);
    flip = 1'b0;
    cyc();           lit("wd_step", 5, 0, 0);
    min_b = 4'd0; max_b = 4'd15;
    cyc(5);          lit("wd_at0", 0, 0, 0);
    cyc();           lit("wd_wrap_0", 15, 0, 1);
    flip = 1'b1;
    cyc();           lit("wd_wrap_15", 0, 1, 1);
    flip = 1'b0;

    // Invalid ranges freeze everything
    mode = 1'b0; min_b = 4'd5; max_b = 4'd2;
    cyc(5);          lit("inv_frozen", 0, 1, 0);
    min_b = 4'd6; max_b = 4'd6; flip = 1'b1;
    cyc(2);          lit("inv_equal", 0, 1, 0);
    flip = 1'b0; min_b = 4'd5; max_b = 4'd9;
    cyc();           lit("inv_resync", 5, 1, 0);
    cyc(2);          lit("inv_count", 7, 1, 0);

    // Hold with enable low (flip ignored), then reset mid-count
    enable = 1'b0; flip = 1'b1;
    cyc(3);          lit("hold", 7, 1, 0);
    enable = 1'b1; flip = 1'b0; rst = 1'b1;
    cyc();           lit("mid_reset", 0, 1, 0);
    rst = 1'b0;
    cyc();           lit("post_reset_resync", 5, 1, 0);
    cyc(5);          lit("post_reset_bounce", 8, 0, 1);

    cyc(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_ping_pong_counter

// File: doc/param_ping_pong_counter.md
PARAM_PING_PONG_COUNTER -- requirements
Module: param_ping_pong_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  count enable; low = hold all state.
REQ-005 SHALL have port mode  input  1  0 = ping-pong (bounce at bounds), 1 = wrap (roll over at bounds).
REQ-006 SHALL have port flip  input  1  reverse direction this cycle; qualified by enable.
REQ-007 SHALL have port min  input  WIDTH  lower bound, inclusive.
REQ-008 SHALL have port max  input  WIDTH  upper bound, inclusive.
REQ-009 SHALL have port direction  output  1  registered; 1 = up, 0 = down.
REQ-010 SHALL have port out  output  WIDTH  registered counter value.
REQ-011 SHALL have port turn  output  1  registered one-cycle pulse on bounce or wrap.

Function
REQ-012 Range valid SHALL mean max > min, unsigned compare; invalid range (max <= min) SHALL hold out and direction, turn=0, regardless of enable.
REQ-013 enable=0 SHALL hold out and direction, turn=0; flip ignored.
REQ-014 With enable=1, valid range and out outside [min,max]: next out=min, direction=1, turn=0 (resync, one cycle).
REQ-015 With enable=1, valid range and out in range: effective direction d = direction XOR flip; d is then used for all boundary rules below.
REQ-016 Interior step (d=1 and out<max, or d=0 and out>min): out +/- 1, direction=d, turn=0.
REQ-017 Ping-pong, d=1, out==max: out=max-1, direction=0, turn=1.
REQ-018 Ping-pong, d=0, out==min: out=min+1, direction=1, turn=1.
REQ-019 Wrap, d=1, out==max: out=min, direction=1, turn=1; d=0, out==min: out=max, direction=0, turn=1.
REQ-020 Arithmetic SHALL be WIDTH-bit unsigned; no state change may overflow/underflow past [min,max] (max=2^WIDTH-1 and min=0 legal).
REQ-021 min/max changes SHALL take effect at the next edge; no internal copy of bounds.
REQ-022 Latency: inputs sampled at edge N are reflected in outputs after edge N; no combinational input-to-output path.

Reset
REQ-023 rst=1 at a rising edge SHALL set out=0, direction=1, turn=0, overriding enable, flip and bounds.
REQ-024 Reset asserted mid-count SHALL take effect at the next edge; first count after release SHALL follow REQ-014..019 (out=0 below min resyncs to min).

Structure
REQ-025 Shared package param_ppc_pkg SHALL hold MODE_PINGPONG=0, MODE_WRAP=1, DIR_UP=1, DIR_DOWN=0; RTL SHALL use these names, not literals.
REQ-026 Single module, no sub-module; next-state logic combinational, one registered state block for out/direction/turn.

Verification (WIDTH=4)
REQ-027 Reset, enable=1, mode=0, min=0, max=15 -> out 0,1..15,14..0,1; direction 1->0 on 15->14, 0->1 on 0->1; turn=1 exactly on those two cycles.
REQ-028 mode=1, min=3, max=6, after reset -> out 0,3(resync, turn=0),4,5,6,3,4; turn=1 only on 6->3; direction stays 1.
REQ-029 mode=0, min=0, max=15, flip=1 one cycle at out=5 going up -> out 4, direction=0; flip at out=15 going up -> out 14 without turn (d=0 interior step).
REQ-030 max=2, min=5, enable=1 for 5 cycles -> out, direction frozen, turn=0; then max=9 -> resync to 5 if outside, else counts.
REQ-031 enable=0 for 3 cycles at out=7, then rst=1 one cycle mid-count -> hold at 7, then out=0, direction=1, turn=0 at the reset edge.
